// File: rtl/router_fifo_pkg.sv
// Shared constants for the 1x3 router: byte width, FIFO depth and header field positions.
package router_pkg;

    localparam int unsigned ROUTER_WIDTH      = 8;
    localparam int unsigned ROUTER_FIFO_DEPTH = 16;
    localparam int unsigned HDR_LEN_MSB       = 7;
    localparam int unsigned HDR_LEN_LSB       = 2;
    localparam int unsigned HDR_ADDR_MSB      = 1;
    localparam int unsigned HDR_ADDR_LSB      = 0;
    localparam int unsigned PKT_CNT_W         = 6;

    // Words left in a packet once its header has been read: payload plus parity.
    function automatic logic [PKT_CNT_W-1:0] hdr_words(input logic [ROUTER_WIDTH-1:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB] + 1'b1;
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake bundle between the synchronizer/destination and one router_fifo.
interface router_fifo_if import router_pkg::*; #(
    parameter int unsigned WIDTH = ROUTER_WIDTH
) ();

    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             overflow_err;
    logic             underflow_err;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, overflow_err, underflow_err
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, overflow_err, underflow_err
    );

endinterface

// File: rtl/router_fifo_ptr.sv
// Wrap-bit read/write pointers for router_fifo: full/empty flags and accept strobes.
module router_fifo_ptr #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    output logic [$clog2(DEPTH):0]   wr_ptr,
    output logic [$clog2(DEPTH):0]   rd_ptr,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_accept,
    output logic                     rd_accept
);

    localparam int unsigned AW = $clog2(DEPTH);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Strobes are suppressed under either reset so the top never acts on a discarded request.
    assign wr_accept = write_enb && !full  && !reset && !soft_reset;
    assign rd_accept = read_enb  && !empty && !reset && !soft_reset;

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router with header marker and packet-length tracking.
// Optional sticky error flags are built when ROUTER_FIFO_ERR_FLAGS_EN is defined.
module router_fifo import router_pkg::*; #(
    parameter int unsigned DEPTH = ROUTER_FIFO_DEPTH,
    parameter int unsigned WIDTH = ROUTER_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH:0]         mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   full;
    logic                   empty;
    logic                   wr_accept;
    logic                   rd_accept;
    logic [WIDTH:0]         rd_word;
    logic [WIDTH-1:0]       data_out;
    logic [PKT_CNT_W-1:0]   pkt_cnt;

    router_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (bus.write_enb),
        .read_enb   (bus.read_enb),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .full       (full),
        .empty      (empty),
        .wr_accept  (wr_accept),
        .rd_accept  (rd_accept)
    );

    always_ff @(posedge clock) begin
        if (wr_accept) mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end

    assign rd_word = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            data_out <= '0;
            pkt_cnt  <= '0;
        end else if (rd_accept) begin
            data_out <= rd_word[WIDTH-1:0];
            if (rd_word[WIDTH])
                pkt_cnt <= hdr_words(rd_word[WIDTH-1:0]);
            else if (pkt_cnt != '0)
                pkt_cnt <= pkt_cnt - 1'b1;
        end else if (pkt_cnt == '0 && empty) begin
            data_out <= '0;
        end
    end

    assign bus.data_out = data_out;
    assign bus.full     = full;
    assign bus.empty    = empty;

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!soft_reset) begin
            if (bus.write_enb && full) overflow_q  <= 1'b1;
            if (bus.read_enb && empty) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;
`else
    assign bus.overflow_err  = 1'b0;
    assign bus.underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: packet read-out, fill, wrap, soft reset, underflow.
module tb_router_fifo;
    import router_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic soft_reset;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    router_fifo_if #(.WIDTH(ROUTER_WIDTH)) bus ();

    router_fifo #(.DEPTH(ROUTER_FIFO_DEPTH), .WIDTH(ROUTER_WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic lfd, input logic [7:0] d);
        bus.write_enb = 1'b1;
        bus.lfd_state = lfd;
        bus.data_in   = d;
        step();
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
    endtask

    logic [7:0] pkt [5];
    logic [7:0] wv;

    initial begin
        pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5C;
        reset = 1'b1;
        soft_reset = 1'b0;
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_dout", 32'(bus.data_out), 0);
        check("rst_ovf", 32'(bus.overflow_err), 0);
        check("rst_udf", 32'(bus.underflow_err), 0);

        // Single packet: header 0x0D carries length 3, so 4 words follow it.
        wr(1'b1, pkt[0]);
        check("wr_empty_low", 32'(bus.empty), 0);
        for (int i = 1; i < 5; i++) wr(1'b0, pkt[i]);
        bus.read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("pkt_rd%0d", i), 32'(bus.data_out), 32'(pkt[i]));
            if (i == 0) check("pkt_cnt_hdr", 32'(dut.pkt_cnt), 4);
        end
        bus.read_enb = 1'b0;
        check("pkt_cnt_end", 32'(dut.pkt_cnt), 0);
        step();
        check("pkt_idle_dout", 32'(bus.data_out), 0);
        check("pkt_idle_empty", 32'(bus.empty), 1);

        // Fill: pointers both sit at 5 here, so 16 writes take wr_ptr to 21.
        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 8'(8'h10 + i));
            if (i == 14) check("fill_not_full15", 32'(bus.full), 0);
        end
        check("fill_full16", 32'(bus.full), 1);
        wr(1'b0, 8'hEE);
        check("fill_full17", 32'(bus.full), 1);
        check("fill_wr_ptr", 32'(dut.u_ptr.wr_ptr), 21);
        check("fill_ovf", 32'(bus.overflow_err), 32'(ERR_EXP));
        bus.read_enb  = 1'b1;
        bus.write_enb = 1'b1;
        bus.data_in   = 8'h77;
        step();
        bus.write_enb = 1'b0;
        check("full_rw_dout", 32'(bus.data_out), 32'h10);
        check("full_rw_full", 32'(bus.full), 0);
        for (int i = 1; i < 16; i++) begin
            step();
            check($sformatf("drain%0d", i), 32'(bus.data_out), 32'(8'h10 + i));
        end
        bus.read_enb = 1'b0;
        check("drain_empty", 32'(bus.empty), 1);
        step();

        // Wrap: one entry of lag, 41 bytes through a 16-deep array.
        wr(1'b0, 8'h21);
        for (int i = 0; i < 40; i++) begin
            bus.write_enb = 1'b1;
            bus.data_in   = 8'(8'h21 + 3 * (i + 1));
            bus.read_enb  = 1'b1;
            step();
            wv = 8'(8'h21 + 3 * i);
            check($sformatf("wrap%0d", i), 32'(bus.data_out), 32'(wv));
            check($sformatf("wrap_full%0d", i), 32'(bus.full), 0);
        end
        bus.write_enb = 1'b0;
        step();
        bus.read_enb = 1'b0;
        wv = 8'(8'h21 + 3 * 40);
        check("wrap_last", 32'(bus.data_out), 32'(wv));
        check("wrap_empty", 32'(bus.empty), 1);

        // Soft reset mid-packet: header 0x14 (length 5) plus 5 words, 2 read out.
        wr(1'b1, 8'h14);
        for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'hB0 + i));
        bus.read_enb = 1'b1;
        step();
        check("sr_rd0", 32'(bus.data_out), 32'h14);
        check("sr_cnt0", 32'(dut.pkt_cnt), 6);
        step();
        bus.read_enb = 1'b0;
        check("sr_rd1", 32'(bus.data_out), 32'hB0);
        check("sr_cnt1", 32'(dut.pkt_cnt), 5);
        soft_reset    = 1'b1;
        bus.write_enb = 1'b1;
        bus.data_in   = 8'h99;
        step();
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        check("sr_empty", 32'(bus.empty), 1);
        check("sr_dout", 32'(bus.data_out), 0);
        check("sr_cnt", 32'(dut.pkt_cnt), 0);
        check("sr_ovf_kept", 32'(bus.overflow_err), 32'(ERR_EXP));

        // Underflow.
        bus.read_enb = 1'b1;
        step();
        bus.read_enb = 1'b0;
        check("udf_rd_ptr", 32'(dut.u_ptr.rd_ptr), 0);
        check("udf_dout", 32'(bus.data_out), 0);
        check("udf_flag", 32'(bus.underflow_err), 32'(ERR_EXP));
        check("udf_empty", 32'(bus.empty), 1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_ovf", 32'(bus.overflow_err), 0);
        check("rst2_udf", 32'(bus.underflow_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
